// File: rtl/uart_tx_ctrl.sv
// UART transmitter control and datapath stage.
// Sequences one frame (start, LSB-first data, optional parity, stop) one bit per CLK
// cycle and drives the line-select code, serial data bit and parity bit for the TX mux.
// All outputs are registered, and each one is computed from the state being entered.

module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            SEL,
  output logic                  ser_out,
  output logic                  parity_out,
  output logic                  BUSY
);

  localparam int CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  // Line-select codes understood by the TX mux
  localparam logic [1:0] SelStart  = 2'b00;
  localparam logic [1:0] SelData   = 2'b01;
  localparam logic [1:0] SelParity = 2'b11;
  localparam logic [1:0] SelStop   = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                r_state;
  logic [1:0]            r_sel;
  logic                  r_ser;
  logic                  r_par;
  logic                  r_busy;
  logic                  r_par_en;
  logic [CntW-1:0]       r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;

  // Frame sequencer with registered outputs. The shift register always holds the
  // not-yet-presented data bits in its low end, so ser_out is loaded from bit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= StIdle;
      r_sel    <= SelStop;
      r_ser    <= 1'b0;
      r_par    <= 1'b0;
      r_busy   <= 1'b0;
      r_par_en <= 1'b0;
      r_cnt    <= '0;
      r_shift  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (DATA_VALID) begin
            r_shift  <= P_DATA;
            r_par_en <= PAR_EN;
            // Parity type folds into the bit at accept, so it need not be kept
            r_par    <= (^P_DATA) ^ PAR_TYP;
            r_state  <= StStart;
            r_sel    <= SelStart;
            r_busy   <= 1'b1;
          end
        end
        StStart: begin
          r_ser   <= r_shift[0];
          r_shift <= r_shift >> 1;
          r_cnt   <= '0;
          r_state <= StData;
          r_sel   <= SelData;
        end
        StData: begin
          if (r_cnt == LastBit) begin
            r_cnt <= '0;
            if (r_par_en) begin
              r_state <= StParity;
              r_sel   <= SelParity;
            end else begin
              r_state <= StStop;
              r_sel   <= SelStop;
            end
          end else begin
            r_ser   <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        StParity: begin
          r_state <= StStop;
          r_sel   <= SelStop;
        end
        StStop: begin
          r_state <= StIdle;
          r_sel   <= SelStop;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_sel   <= SelStop;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign SEL        = r_sel;
  assign ser_out    = r_ser;
  assign parity_out = r_par;
  assign BUSY       = r_busy;

endmodule
